st7735_spi_rx: RTL
==================

Name: st7735_spi_rx

Overview:
- SPI-slave front end for the ST7735R-compatible display controller. Receives 4-wire SPI (SCK, CS#, MOSI, D/C) from the ESP32 host, oversampled in the system clock domain.
- Decodes the command/parameter stream into single-cycle pulses: instruction, pixel, column-window and row-window.
- Sits directly upstream of the display/SRAM control stage, which consumes these pulses.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (min 2).
- DEF_COL_END, 479, column end loaded at reset/SWRESET (display width - 1).
- DEF_ROW_END, 271, row end loaded at reset/SWRESET (display height - 1).

Ports:
- i_clk  in  1  system clock (mco); all logic on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_spi_clk  in  1  SPI SCK, mode 0, asynchronous to i_clk.
- i_spi_cs  in  1  SPI chip select, active low.
- i_spi_mosi  in  1  SPI data, MSB first.
- i_dc  in  1  D/C: 1 = data/parameter, 0 = command.
- o_inst_data  out  8  last command byte.
- o_inst_en_pls  out  1  one-cycle pulse, o_inst_data valid.
- o_pixel_data  out  16  RGB565 pixel, first byte in [15:8].
- o_pixel_en_pls  out  1  one-cycle pulse, o_pixel_data valid.
- o_col_addr  out  32  {XS[15:0], XE[15:0]}.
- o_col_addr_en_pls  out  1  one-cycle pulse on o_col_addr update.
- o_row_addr  out  32  {YS[15:0], YE[15:0]}.
- o_row_addr_en_pls  out  1  one-cycle pulse on o_row_addr update.

Behaviour:
- Reset values:
  - All pulses 0; o_inst_data 8'h00; o_pixel_data 0.
  - o_col_addr = {16'd0, DEF_COL_END}; o_row_addr = {16'd0, DEF_ROW_END}.
  - State IDLE; bit count 0; pixel phase 0; param index 0.
- Synchronisers: SCK, CS, MOSI and DC each pass through SYNC_STAGES flops. A rising SCK edge is detected as sync==1 with a previous sample of 0, while synced CS==0.
- SCK constraint: SCK <= i_clk/8. This guarantees one pixel per >= 64 i_clk cycles, which downstream requires.
- Bit shift: each rising SCK edge shifts MOSI into an 8-bit shift register, MSB first, and increments a 3-bit count.
- Byte completion: on the 8th edge the byte completes and DC is sampled on that same edge. The resulting output pulse is asserted exactly 1 i_clk cycle after the edge-detect cycle.
- CS high: bit count clears immediately, discarding any partial byte.
  - Command state, pixel phase and param index are retained, so command and parameters may arrive in separate CS transactions.
- Pulses are mutually exclusive; at most one byte completes per cycle.
- Command byte (DC=0):
  - Load o_inst_data and pulse o_inst_en_pls.
  - Reset pixel phase and param index to 0.
  - Next state: 2Ah -> CASET; 2Bh -> RASET; 2Ch -> RAMWR; any other value -> IDLE.
  - 01h (SWRESET) additionally reloads o_col_addr/o_row_addr to their reset values, with no addr pulses.
- Data byte (DC=1), by state:
  - IDLE: byte discarded, no pulse.
  - CASET/RASET: bytes 0..3 fill a shadow register big-endian (byte0 -> [31:24] ... byte3 -> [7:0]).
    - On byte 3, the shadow is copied to o_col_addr (CASET) or o_row_addr (RASET) and the matching en pulse is asserted once.
    - Param index saturates at 4; extra bytes are discarded.
    - Fewer than 4 bytes followed by a new command: the output is unchanged and the shadow is discarded.
  - RAMWR: phase 0 stores the byte as the high byte and sets phase to 1.
    - Phase 1 outputs {high, byte} on o_pixel_data, pulses o_pixel_en_pls and sets phase to 0.
    - Unbounded stream; a dangling odd byte is dropped on the next command.
- No range checking of XS/XE/YS/YE; values pass through as received.
- Reset asserted mid-byte or mid-parameter: all state returns to reset values immediately; no pulse is emitted.

Test Plan:
- Reset -> o_col_addr=32'h0000_01DF, o_row_addr=32'h0000_010F, all pulses 0; bytes with DC=1 in IDLE produce no pulses.
- CMD 2Ah, data 00 0A 00 63 -> one o_col_addr_en_pls, o_col_addr=32'h000A_0063, o_inst_data=8'h2A pulsed once before it; same sequence with 2Bh -> o_row_addr=32'h000A_0063 and one row pulse.
- CMD 2Ch, data F8 00 07 E0 -> two o_pixel_en_pls, values 16'hF800 then 16'h07E0; each pulse exactly 1 cycle after the 8th SCK edge detect of byte 2/4.
- CS toggled high between every byte of a RAMWR stream, plus a CS rise after 5 bits of a byte -> partial byte dropped; pixels still pair correctly across CS transactions.
- CASET with only 2 params then CMD 2Ch -> o_col_addr unchanged, no col pulse; CMD 01h after a CASET -> o_col_addr back to 32'h0000_01DF, o_inst_en_pls with 8'h01.
- Async i_rst asserted after 12 SCK edges of a RAMWR stream -> no pixel pulse; state IDLE; next 2 data bytes ignored until a new 2Ch.

Source files
------------

// File: rtl/st7735_spi_rx.sv
// SPI-slave front end for an ST7735R-style display controller: oversamples
// SCK/CS/MOSI/DC in the system clock domain and turns the byte stream into pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no active command, data bytes are discarded
// ST_CASET | collecting XS/XE column-window parameters
// ST_RASET | collecting YS/YE row-window parameters
// ST_RAMWR | streaming RGB565 pixels, two bytes per pixel
module st7735_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEF_COL_END = 479,
    parameter int DEF_ROW_END = 271
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_spi_clk,
    input  logic        i_spi_cs,
    input  logic        i_spi_mosi,
    input  logic        i_dc,
    output logic [7:0]  o_inst_data,
    output logic        o_inst_en_pls,
    output logic [15:0] o_pixel_data,
    output logic        o_pixel_en_pls,
    output logic [31:0] o_col_addr,
    output logic        o_col_addr_en_pls,
    output logic [31:0] o_row_addr,
    output logic        o_row_addr_en_pls
);

    localparam logic [31:0] COL_RST     = {16'd0, 16'(DEF_COL_END)};
    localparam logic [31:0] ROW_RST     = {16'd0, 16'(DEF_ROW_END)};
    localparam logic [7:0]  CMD_SWRESET = 8'h01;
    localparam logic [7:0]  CMD_CASET   = 8'h2A;
    localparam logic [7:0]  CMD_RASET   = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR   = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   dc_s;
    logic                   sck_rise;

    logic [6:0]  shift_q;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_byte;
    logic        byte_done;

    logic        pix_phase;
    logic [7:0]  pix_high_q;
    logic [2:0]  param_idx;
    logic [23:0] shadow_q;

    // CS sync resets high so nothing is seen as selected while coming out of reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], i_dc};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev & ~cs_s;
    assign rx_byte   = {shift_q, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (cs_s) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shift_q <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (byte_done && !dc_s) begin
            case (rx_byte)
                CMD_CASET: state_nxt = ST_CASET;
                CMD_RASET: state_nxt = ST_RASET;
                CMD_RAMWR: state_nxt = ST_RAMWR;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_inst_data       <= 8'h00;
            o_inst_en_pls     <= 1'b0;
            o_pixel_data      <= 16'h0000;
            o_pixel_en_pls    <= 1'b0;
            o_col_addr        <= COL_RST;
            o_col_addr_en_pls <= 1'b0;
            o_row_addr        <= ROW_RST;
            o_row_addr_en_pls <= 1'b0;
            pix_phase         <= 1'b0;
            pix_high_q        <= 8'h00;
            param_idx         <= 3'd0;
            shadow_q          <= '0;
        end else begin
            o_inst_en_pls     <= 1'b0;
            o_pixel_en_pls    <= 1'b0;
            o_col_addr_en_pls <= 1'b0;
            o_row_addr_en_pls <= 1'b0;
            if (byte_done) begin
                if (!dc_s) begin
                    o_inst_data   <= rx_byte;
                    o_inst_en_pls <= 1'b1;
                    pix_phase     <= 1'b0;
                    param_idx     <= 3'd0;
                    shadow_q      <= '0;
                    if (rx_byte == CMD_SWRESET) begin
                        o_col_addr <= COL_RST;
                        o_row_addr <= ROW_RST;
                    end
                end else begin
                    case (state_q)
                        ST_CASET, ST_RASET: begin
                            // index stops at 4 so surplus parameters fall through untouched
                            if (param_idx < 3'd4) begin
                                param_idx <= param_idx + 3'd1;
                                case (param_idx)
                                    3'd0: shadow_q[23:16] <= rx_byte;
                                    3'd1: shadow_q[15:8]  <= rx_byte;
                                    3'd2: shadow_q[7:0]   <= rx_byte;
                                    3'd3: begin
                                        if (state_q == ST_CASET) begin
                                            o_col_addr        <= {shadow_q, rx_byte};
                                            o_col_addr_en_pls <= 1'b1;
                                        end else begin
                                            o_row_addr        <= {shadow_q, rx_byte};
                                            o_row_addr_en_pls <= 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        ST_RAMWR: begin
                            if (!pix_phase) begin
                                pix_high_q <= rx_byte;
                                pix_phase  <= 1'b1;
                            end else begin
                                o_pixel_data   <= {pix_high_q, rx_byte};
                                o_pixel_en_pls <= 1'b1;
                                pix_phase      <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
